bp_be_branch_resolver: RTL and testbench

//  Backend end of the FE branch-feedback interface. Takes resolved control-flow results from the execute stage
//  and compares each actual target against the FE-predicted next PC. Mispredictions and traps produce a

---
 rtl/bp_be_branch_resolver_pkg.sv | 61 ++++++
 rtl/bp_be_branch_resolver_attaboy_queue.sv | 57 +++++
 rtl/bp_be_branch_resolver.sv | 134 +++++++++++++
 tb/tb_bp_be_branch_resolver.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_branch_resolver_pkg.sv
// bp_be_branch_resolver_pkg: config, fetch-metadata layout and
// resolve/redirect/attaboy bundles shared by the BE branch resolver.
package bp_be_branch_resolver_pkg;

   typedef enum logic [0:0] {
      e_bp_default_cfg
   } bp_cfg_e;

   function automatic int bp_vaddr_width(bp_cfg_e cfg);
      int w;
      unique case (cfg)
         e_bp_default_cfg: w = 39;
         default:          w = 39;
      endcase
      return w;
   endfunction

   localparam int vaddr_width_gp = bp_vaddr_width(e_bp_default_cfg);

   typedef struct packed {
      logic [7:0] ghist;
      logic [5:0] bht_row;
      logic [1:0] bht_val;
      logic       src_btb;
      logic       is_jalr;
      logic       is_jal;
      logic       is_br;
   } bp_fe_branch_metadata_fwd_s;

   localparam int branch_metadata_fwd_width_gp =
      $bits(bp_fe_branch_metadata_fwd_s);

   typedef struct packed {
      logic                       epoch;
      logic [vaddr_width_gp-1:0]  pc;
      logic [vaddr_width_gp-1:0]  npc_pred;
      logic [vaddr_width_gp-1:0]  tgt;
      logic                       taken;
      bp_fe_branch_metadata_fwd_s metadata;
   } bp_be_resolve_s;

   typedef struct packed {
      bp_fe_branch_metadata_fwd_s metadata;
      logic                       taken;
      logic                       ntaken;
   } bp_be_attaboy_s;

   typedef struct packed {
      logic [vaddr_width_gp-1:0]  pc;
      logic                       br_v;
      bp_fe_branch_metadata_fwd_s metadata;
      logic                       taken;
      logic                       ntaken;
   } bp_be_redirect_s;

   typedef enum logic [0:0] {
      e_run,
      e_redir
   } bp_be_resolver_state_e;

endpackage

// File: rtl/bp_be_branch_resolver_attaboy_queue.sv
// bp_be_branch_resolver_attaboy_queue: small 1r1w FIFO of correct
// predictions, drained by the FE with valid-yumi.
module bp_be_branch_resolver_attaboy_queue
   import bp_be_branch_resolver_pkg::*;
 #(parameter int els_p = 4
   ,localparam int ptr_w_lp = $clog2(els_p)
   )
  (input  logic           clk_i
   ,input  logic           reset_i
   ,input  logic           v_i
   ,input  bp_be_attaboy_s data_i
   ,output logic           ready_o
   ,output logic           v_o
   ,output bp_be_attaboy_s data_o
   ,input  logic           yumi_i
   );

   typedef logic [ptr_w_lp-1:0] ptr_t;
   typedef logic [ptr_w_lp:0]   cnt_t;

   bp_be_attaboy_s mem_r [els_p];
   ptr_t           wptr_r;
   ptr_t           rptr_r;
   cnt_t           cnt_r;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;

   // depth is a power of two, so the count MSB alone marks full
   assign full  = cnt_r[ptr_w_lp];
   assign empty = (cnt_r == '0);
   assign push  = v_i & ~full;
   assign pop   = yumi_i & ~empty;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_r <= '0;
         rptr_r <= '0;
         cnt_r  <= '0;
      end else begin
         wptr_r <= wptr_r + ptr_t'(push);
         rptr_r <= rptr_r + ptr_t'(pop);
         cnt_r  <= cnt_r + cnt_t'(push) - cnt_t'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         mem_r[wptr_r] <= data_i;
   end

   assign ready_o = ~full;
   assign v_o     = ~empty;
   assign data_o  = empty ? '0 : mem_r[rptr_r];

endmodule

// File: rtl/bp_be_branch_resolver.sv
// bp_be_branch_resolver: compares resolved targets against FE predictions,
// issues one-cycle redirects and queues attaboys for correct predictions.
module bp_be_branch_resolver
   import bp_be_branch_resolver_pkg::*;
 #(parameter bp_cfg_e bp_params_p = e_bp_default_cfg
   ,parameter int attaboy_els_p = 4
   ,localparam int vaddr_width_p = bp_vaddr_width(bp_params_p)
   ,localparam int bmfw_p = branch_metadata_fwd_width_gp
   )
  (input  logic                     clk_i
   ,input  logic                     reset_i
   ,input  logic                     resolve_v_i
   ,output logic                     resolve_ready_o
   ,input  logic                     resolve_epoch_i
   ,input  logic [vaddr_width_p-1:0] resolve_pc_i
   ,input  logic [vaddr_width_p-1:0] resolve_npc_pred_i
   ,input  logic [vaddr_width_p-1:0] resolve_tgt_i
   ,input  logic                     resolve_taken_i
   ,input  logic [bmfw_p-1:0]        resolve_br_metadata_i
   ,input  logic                     trap_v_i
   ,input  logic [vaddr_width_p-1:0] trap_pc_i
   ,output logic                     redirect_v_o
   ,output logic [vaddr_width_p-1:0] redirect_pc_o
   ,output logic                     redirect_br_v_o
   ,output logic [bmfw_p-1:0]        redirect_br_metadata_o
   ,output logic                     redirect_br_taken_o
   ,output logic                     redirect_br_ntaken_o
   ,output logic                     attaboy_v_o
   ,input  logic                     attaboy_yumi_i
   ,output logic [bmfw_p-1:0]        attaboy_br_metadata_o
   ,output logic                     attaboy_taken_o
   ,output logic                     attaboy_ntaken_o
   );

   bp_be_resolve_s             res;
   bp_fe_branch_metadata_fwd_s md;
   bp_be_attaboy_s             ab_entry;
   bp_be_attaboy_s             ab_head;
   bp_be_redirect_s            redir_n;
   bp_be_redirect_s            redir_r;
   bp_be_resolver_state_e      state_n;
   bp_be_resolver_state_e      state_r;
   logic                       epoch_r;
   logic                       accept;
   logic                       cf;
   logic                       mis;
   logic                       cur;
   logic                       mis_evt;
   logic                       push;
   logic                       redir_evt;
   logic                       unused_pc;

   assign res = '{epoch:    resolve_epoch_i
                 ,pc:       resolve_pc_i
                 ,npc_pred: resolve_npc_pred_i
                 ,tgt:      resolve_tgt_i
                 ,taken:    resolve_taken_i
                 ,metadata: bp_fe_branch_metadata_fwd_s'(resolve_br_metadata_i)
                 };
   assign md        = res.metadata;
   assign unused_pc = ^res.pc;

   assign accept  = resolve_v_i & resolve_ready_o;
   assign cf      = md.is_br | md.is_jal | md.is_jalr;
   assign mis     = (res.tgt != res.npc_pred);
   assign cur     = (res.epoch == epoch_r);
   // a trap wins the cycle; the resolve is still consumed silently
   assign mis_evt = accept & cur & mis & ~trap_v_i;
   assign push    = accept & cur & ~mis & cf & ~trap_v_i;

   assign ab_entry = '{metadata: md
                      ,taken:    res.taken
                      ,ntaken:   md.is_br & ~res.taken
                      };

   always_comb begin
      state_n = e_run;
      redir_n = '0;
      unique case (1'b1)
         trap_v_i: begin
            state_n    = e_redir;
            redir_n.pc = trap_pc_i;
         end
         mis_evt: begin
            state_n          = e_redir;
            redir_n.pc       = res.tgt;
            redir_n.br_v     = cf | md.src_btb;
            redir_n.metadata = md;
            redir_n.taken    = ab_entry.taken;
            redir_n.ntaken   = ab_entry.ntaken;
         end
         default: ;
      endcase
   end

   assign redir_evt = (state_n == e_redir);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= e_run;
         redir_r <= '0;
         epoch_r <= 1'b0;
      end else begin
         state_r <= state_n;
         redir_r <= redir_n;
         epoch_r <= epoch_r ^ redir_evt;
      end
   end

   assign redirect_v_o           = (state_r == e_redir);
   assign redirect_pc_o          = redir_r.pc;
   assign redirect_br_v_o        = redir_r.br_v;
   assign redirect_br_metadata_o = redir_r.metadata;
   assign redirect_br_taken_o    = redir_r.taken;
   assign redirect_br_ntaken_o   = redir_r.ntaken;

   bp_be_branch_resolver_attaboy_queue
    #(.els_p(attaboy_els_p))
    queue
     (.clk_i   (clk_i)
      ,.reset_i (reset_i)
      ,.v_i     (push)
      ,.data_i  (ab_entry)
      ,.ready_o (resolve_ready_o)
      ,.v_o     (attaboy_v_o)
      ,.data_o  (ab_head)
      ,.yumi_i  (attaboy_yumi_i)
      );

   assign attaboy_br_metadata_o = ab_head.metadata;
   assign attaboy_taken_o       = ab_head.taken;
   assign attaboy_ntaken_o      = ab_head.ntaken;

endmodule

// File: tb/tb_bp_be_branch_resolver.sv
// tb_bp_be_branch_resolver: directed vectors against a queue-based
// behavioural model, plus hand-computed literal expectations.
module tb_bp_be_branch_resolver;

   localparam int VA = 39;
   localparam int MW = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          rv;
   logic          ready;
   logic          epoch;
   logic [VA-1:0] pc;
   logic [VA-1:0] pred;
   logic [VA-1:0] tgt;
   logic          taken;
   logic [MW-1:0] md;
   logic          trap;
   logic [VA-1:0] trap_pc;
   logic          r_v;
   logic [VA-1:0] r_pc;
   logic          r_br;
   logic [MW-1:0] r_md;
   logic          r_t;
   logic          r_nt;
   logic          a_v;
   logic          yumi;
   logic [MW-1:0] a_md;
   logic          a_t;
   logic          a_nt;

   int nv = 0;
   int nf = 0;
   bit run = 0;

   bp_be_branch_resolver dut
     (.clk_i                  (clk)
      ,.reset_i                (reset)
      ,.resolve_v_i            (rv)
      ,.resolve_ready_o        (ready)
      ,.resolve_epoch_i        (epoch)
      ,.resolve_pc_i           (pc)
      ,.resolve_npc_pred_i     (pred)
      ,.resolve_tgt_i          (tgt)
      ,.resolve_taken_i        (taken)
      ,.resolve_br_metadata_i  (md)
      ,.trap_v_i               (trap)
      ,.trap_pc_i              (trap_pc)
      ,.redirect_v_o           (r_v)
      ,.redirect_pc_o          (r_pc)
      ,.redirect_br_v_o        (r_br)
      ,.redirect_br_metadata_o (r_md)
      ,.redirect_br_taken_o    (r_t)
      ,.redirect_br_ntaken_o   (r_nt)
      ,.attaboy_v_o            (a_v)
      ,.attaboy_yumi_i         (yumi)
      ,.attaboy_br_metadata_o  (a_md)
      ,.attaboy_taken_o        (a_t)
      ,.attaboy_ntaken_o       (a_nt)
      );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      nv++;
      if (a !== e) begin
         nf++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask

   // behavioural model: metadata bit0 is_br, bit1 is_jal, bit2 is_jalr, bit3 src_btb
   typedef struct packed {
      logic [MW-1:0] md;
      logic          t;
      logic          nt;
   } ab_t;

   ab_t           q[$];
   bit            m_epoch;
   bit            m_rv;
   bit            m_rtrap;
   logic [VA-1:0] m_rpc;
   bit            m_rbr;
   bit            m_rt;
   bit            m_rnt;
   logic [MW-1:0] m_rmd;

   always @(posedge clk or posedge reset) begin
      bit acc, cur, mis, cf, good;
      if (reset) begin
         q.delete();
         m_epoch = 0;
         m_rv = 0; m_rtrap = 0; m_rpc = '0;
         m_rbr = 0; m_rt = 0; m_rnt = 0; m_rmd = '0;
      end else begin
         acc  = rv && (q.size() < 4);
         cur  = (epoch == m_epoch);
         mis  = (tgt != pred);
         cf   = md[0] | md[1] | md[2];
         good = acc && cur && !mis && cf && !trap;
         m_rv = 0; m_rtrap = 0; m_rpc = '0;
         m_rbr = 0; m_rt = 0; m_rnt = 0; m_rmd = '0;
         if (trap) begin
            m_rv = 1; m_rtrap = 1; m_rpc = trap_pc;
         end else if (acc && cur && mis) begin
            m_rv  = 1;
            m_rpc = tgt;
            m_rbr = cf | md[3];
            m_rmd = md;
            m_rt  = taken;
            m_rnt = md[0] & ~taken;
         end
         if (yumi && q.size() > 0)
            void'(q.pop_front());
         if (good)
            q.push_back('{md: md, t: taken, nt: md[0] & ~taken});
         if (m_rv)
            m_epoch = ~m_epoch;
      end
   end

   always @(negedge clk) begin
      if (run && !reset) begin
         chk("ready", ready, q.size() < 4);
         chk("redir_v", r_v, m_rv);
         if (m_rv) begin
            chk("redir_pc", r_pc, m_rpc);
            chk("redir_br_v", r_br, m_rbr);
            if (!m_rtrap) begin
               chk("redir_md", r_md, m_rmd);
               chk("redir_taken", r_t, m_rt);
               chk("redir_ntaken", r_nt, m_rnt);
            end
         end
         chk("ab_v", a_v, q.size() != 0);
         if (q.size() != 0) begin
            chk("ab_md", a_md, q[0].md);
            chk("ab_taken", a_t, q[0].t);
            chk("ab_ntaken", a_nt, q[0].nt);
         end
         nv++;
         assert (!(yumi && !a_v)) else begin
            nf++;
            $display("FAIL yumi_illegal: yumi %b while attaboy_v %b", yumi, a_v);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      rv = 0; epoch = 0; pc = '0; pred = '0; tgt = '0;
      taken = 0; md = '0; trap = 0; trap_pc = '0;
   endtask

   task automatic res(input logic ep, input logic [VA-1:0] p, input logic [VA-1:0] pr,
                      input logic [VA-1:0] t, input logic tk, input logic [MW-1:0] m);
      rv = 1; epoch = ep; pc = p; pred = pr; tgt = t; taken = tk; md = m;
   endtask

   localparam logic [VA-1:0] A100 = 39'h80000100;

   initial begin
      reset = 1; yumi = 0;
      idle();
      tick(); tick();
      chk("rst_ready", ready, 1);
      chk("rst_redir_v", r_v, 0);
      chk("rst_ab_v", a_v, 0);
      chk("rst_ab_md", a_md, 0);
      reset = 0; run = 1;
      tick();

      // 1: correct taken branch
      res(0, 39'h800000FC, A100, A100, 1, 20'hA5C01);
      tick(); idle();
      chk("t1_ab_v", a_v, 1);
      chk("t1_taken", a_t, 1);
      chk("t1_ntaken", a_nt, 0);
      chk("t1_md", a_md, 20'hA5C01);
      chk("t1_redir_v", r_v, 0);
      yumi = 1; tick(); yumi = 0;

      // 2: not-taken branch predicted taken
      res(0, 39'h80000000, A100, 39'h80000004, 0, 20'h12301);
      tick(); idle();
      chk("t2_redir_v", r_v, 1);
      chk("t2_pc", r_pc, 39'h80000004);
      chk("t2_br_v", r_br, 1);
      chk("t2_ntaken", r_nt, 1);
      chk("t2_taken", r_t, 0);
      tick();
      chk("t2_pulse", r_v, 0);

      // 3: stale epoch is discarded
      res(0, 39'h80000010, A100, 39'h80000200, 1, 20'h00001);
      chk("t3_ready", ready, 1);
      tick(); idle();
      chk("t3_redir_v", r_v, 0);
      chk("t3_ab_v", a_v, 0);

      // 4: fill, stall, one pop, then drain in order
      for (int i = 0; i < 4; i++) begin
         res(1, 39'h80001000, A100, A100, 1, {8'(i + 1), 12'h002});
         tick();
      end
      idle();
      chk("t4_full", ready, 0);
      res(1, 39'h80001000, A100, A100, 1, {8'd5, 12'h002});
      yumi = 1; tick(); yumi = 0;
      chk("t4_reopen", ready, 1);
      chk("t4_head", a_md, {8'd2, 12'h002});
      tick(); idle();
      chk("t4_refull", ready, 0);
      for (int k = 0; k < 4; k++) begin
         chk("t4_order", a_md, {8'(k + 2), 12'h002});
         yumi = 1; tick();
      end
      yumi = 0;
      chk("t4_empty", a_v, 0);

      // 5: trap beats a same-cycle mispredict
      res(1, 39'h80002000, A100, 39'h80000300, 1, 20'h00001);
      trap = 1; trap_pc = 39'h00001000;
      tick(); idle();
      chk("t5_redir_v", r_v, 1);
      chk("t5_pc", r_pc, 39'h00001000);
      chk("t5_br_v", r_br, 0);
      chk("t5_ab_v", a_v, 0);
      tick();

      // mixed: jalr attaboy, push+pop, non-cf, btb-only and back-to-back redirects
      res(m_epoch, 39'h80003000, A100, A100, 1, 20'h55004);
      tick();
      res(m_epoch, 39'h80003004, A100, A100, 0, 20'h66001);
      yumi = 1; tick(); yumi = 0; idle();
      chk("mx_pushpop_v", a_v, 1);
      chk("mx_pushpop_md", a_md, 20'h66001);
      chk("mx_pushpop_nt", a_nt, 1);
      res(m_epoch, 39'h80003008, A100, A100, 0, 20'h00000);
      tick();
      res(m_epoch, 39'h8000300C, A100, 39'h80003010, 0, 20'h00008);
      tick();
      chk("mx_btb_br_v", r_br, 1);
      chk("mx_btb_t", r_t, 0);
      res(m_epoch, 39'h80003010, A100, 39'h80000200, 1, 20'h77001);
      tick(); idle();
      chk("mx_b2b_v", r_v, 1);
      chk("mx_b2b_pc", r_pc, 39'h80000200);
      chk("mx_b2b_taken", r_t, 1);
      yumi = 1; tick(); yumi = 0;

      // 6: reset during a redirect pulse
      res(m_epoch, 39'h80004000, A100, A100, 1, 20'h00002);
      tick();
      res(m_epoch, 39'h80004004, A100, 39'h80000400, 1, 20'h00002);
      tick(); idle();
      chk("t6_pre_redir", r_v, 1);
      chk("t6_pre_ab", a_v, 1);
      reset = 1;
      #1;
      chk("t6_redir_low", r_v, 0);
      chk("t6_ab_low", a_v, 0);
      tick();
      reset = 0;
      tick();
      chk("t6_empty", a_v, 0);
      chk("t6_ready", ready, 1);
      res(0, 39'h80005000, A100, A100, 1, 20'h00001);
      tick(); idle();
      chk("t6_epoch0", a_v, 1);
      yumi = 1; tick(); yumi = 0;
      tick(); tick();
      run = 0;

      $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
      $finish;
   end

endmodule
